// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - tx_state_e    : transmit FSM states
//   - REG_*         : register offsets in the CPU window
//   - STAT_*        : bit positions inside the STATUS register
//   - CTRL_IEN      : interrupt-enable bit inside CTRL
//   - calc_divisor  : clocks per bit, rounded to nearest
// Optional feature macro: UART_TX_PARITY_EN (PARITY state only used when set).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVERRUN = 3;
  localparam int STAT_IRQ     = 7;

  localparam int CTRL_IEN = 0;

  // Clocks per bit period, rounded to the nearest integer.
  function automatic int calc_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push       : write wdata (accepted when not full, or when full and popping)
//   pop        : drop the head entry (ignored when empty)
//   wdata      : write data
//   rdata      : head entry, valid while empty = 0
//   full/empty : occupancy flags
// Parameters: WIDTH (data bits), DEPTH (entries, power of two, >= 2).
// -----------------------------------------------------------------------------
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A simultaneous pop frees the slot the push needs, so both go through.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter with a 6502-style register window.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   cs, we     : register select / write strobe (we=0 is a read)
//   addr       : 0 DATA (write pushes), 1 STATUS, 2 CTRL (bit0 ien), 3 unused
//   din        : write data
//   dout       : registered read data, updated the edge after a read cycle
//   irq        : registered level interrupt = ien & empty & ~busy
//   tx_n       : registered, inverted serial line (0 = idle/mark)
// Parameters: CLK_HZ, BAUD, FIFO_DEPTH.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (11-bit
// frame); without it frames are 10 bits.
// Handshake: the CPU side has no back-pressure; a DATA write in a cs&we cycle
// is taken on that edge, or dropped and flagged as overrun if the FIFO is full
// and no pop happens on the same edge.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       tx_n
);

  localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  // Bus decode
  logic bus_wr;
  logic bus_rd;
  logic fifo_push;
  logic ctrl_wr;
  logic status_rd;

  assign bus_wr    = cs & we;
  assign bus_rd    = cs & ~we;
  assign fifo_push = bus_wr && (addr == REG_DATA);
  assign ctrl_wr   = bus_wr && (addr == REG_CTRL);
  assign status_rd = bus_rd && (addr == REG_STATUS);

  // FIFO
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transmit FSM state and datapath
  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             line;
  logic             bit_end;
  logic             busy;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign bit_end = (baud_cnt_q == CNT_LAST);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    line     = 1'b1;
    case (state_q)
      IDLE: begin
        line = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        line = shreg_q[0];
        if (bit_end && (bit_cnt_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line = parity_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        line = 1'b1;
        if (bit_end) begin
          // Chain straight into the next frame when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      // The counter rests at 0 while idle so a new frame starts a full period.
      if ((state_q == IDLE) || bit_end) baud_cnt_q <= '0;
      else                              baud_cnt_q <= baud_cnt_q + 1'b1;

      if (fifo_pop) begin
        shreg_q   <= fifo_rdata;
        bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q  <= ^fifo_rdata;
`endif
      end else if ((state_q == DATA) && bit_end) begin
        shreg_q   <= shreg_q >> 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  // Register file and outputs
  logic       ien_q;
  logic       overrun_q;
  logic       overrun_ev;
  logic [7:0] rd_data;

  assign overrun_ev = fifo_push & fifo_full & ~fifo_pop;

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      REG_STATUS: begin
        rd_data[STAT_FULL]    = fifo_full;
        rd_data[STAT_EMPTY]   = fifo_empty;
        rd_data[STAT_BUSY]    = busy;
        rd_data[STAT_OVERRUN] = overrun_q;
        rd_data[STAT_IRQ]     = irq;
      end
      REG_CTRL: begin
        rd_data[CTRL_IEN] = ien_q;
      end
      default: begin
        rd_data = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_n      <= 1'b0;
      dout      <= 8'h00;
      irq       <= 1'b0;
      ien_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tx_n <= ~line;
      irq  <= ien_q & fifo_empty & ~busy;
      if (bus_rd)  dout  <= rd_data;
      if (ctrl_wr) ien_q <= din[CTRL_IEN];
      // A new overrun on the same edge as a STATUS read wins over the clear.
      if (overrun_ev)     overrun_q <= 1'b1;
      else if (status_rd) overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo at CLK_HZ=16, BAUD=1 (16 clocks per bit).
// Bytes written to DATA are queued in exp_q; a line monitor decodes frames
// from tx_n and compares them against the queue head.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * DIV;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic       tx_n;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .irq   (irq),
    .tx_n  (tx_n)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txn(input logic [7:0] d, input int b);
    if (b == 0) return 1'b1;
    if (b <= 8) return ~d[b-1];
    if ((FB == 11) && (b == 9)) return ~(^d);
    return 1'b0;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    if (a == 2'd0) exp_q.push_back(d);
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    d = dout;
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      read_reg(2'd1, s);
      if (!s[2] && s[1]) break;
    end
    check(tag, {30'd0, s[2], s[1]}, 32'h1);
  endtask

  // Cycle-exact tx_n check for nf back-to-back frames. On entry the caller is
  // just after edge N+k0-1, where edge N accepted the first write.
  task automatic wave_check(input logic [7:0] b0, input logic [7:0] b1,
                            input int nf, input int k0, input string tag);
    int last;
    logic e;
    last = 1 + nf * FRAME;
    for (int k = k0; k <= last + 1; k++) begin
      tick();
      if (k < 2 || k > last) e = 1'b0;
      else e = exp_txn((((k - 2) / FRAME) == 0) ? b0 : b1, ((k - 2) % FRAME) / DIV);
      check(tag, {31'd0, tx_n}, {31'd0, e});
    end
  endtask

  // Line monitor / scoreboard
  initial begin
    bit         mon_busy;
    int         mon_cnt;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;
    mon_busy = 0;
    mon_cnt  = 0;
    mon_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_busy = 0;
      end else if (!mon_busy) begin
        if (tx_n) begin
          mon_busy = 1;
          mon_cnt  = 0;
        end
      end else begin
        mon_cnt++;
        if ((mon_cnt >= DIV / 2 + DIV) && (mon_cnt <= DIV / 2 + 8 * DIV) &&
            (((mon_cnt - DIV / 2) % DIV) == 0))
          mon_byte = {~tx_n, mon_byte[7:1]};
        if (mon_cnt == DIV / 2 + (FB - 1) * DIV) begin
          mon_busy = 0;
          check("mon_stop", {31'd0, tx_n}, 32'd0);
          if (exp_q.size() == 0) begin
            check("mon_unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check("mon_byte", {24'd0, mon_byte}, {24'd0, exp_b});
          end
        end
      end
    end
  end

  // Directed sequence
  initial begin
    logic [7:0] rd;
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
    repeat (3) tick();
    check("reset_tx_n", {31'd0, tx_n}, 32'd0);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick();
    read_reg(2'd1, rd);
    check("reset_status", {24'd0, rd}, 32'h02);
    read_reg(2'd2, rd);
    check("reset_ctrl", {24'd0, rd}, 32'h00);

    // Register window corners
    write_reg(2'd3, 8'hFF);
    read_reg(2'd2, rd);
    check("addr3_write_ignored", {24'd0, rd}, 32'h00);
    write_reg(2'd2, 8'hFF);
    read_reg(2'd2, rd);
    check("ctrl_readback", {24'd0, rd}, 32'h01);
    tick();
    check("dout_hold", {24'd0, dout}, 32'h01);
    read_reg(2'd3, rd);
    check("addr3_read", {24'd0, rd}, 32'h00);
    read_reg(2'd0, rd);
    check("data_read", {24'd0, rd}, 32'h00);
    write_reg(2'd2, 8'h00);
    tick();

    // Single byte, exact waveform
    write_reg(2'd0, 8'h55);
    wave_check(8'h55, 8'h00, 1, 1, "single_wave");
    read_reg(2'd1, rd);
    check("single_idle_status", {24'd0, rd}, 32'h02);

    // Back-to-back frames without a gap
    write_reg(2'd0, 8'hA5);
    write_reg(2'd0, 8'h3C);
    wave_check(8'hA5, 8'h3C, 2, 2, "b2b_wave");
    wait_idle("b2b_idle");

    // Overrun: ten writes while the first byte is still in START
    for (int i = 0; i < 10; i++) begin
      if (i < 9) write_reg(2'd0, 8'h80 + 8'(i));
      else begin
        cs = 1'b1; we = 1'b1; addr = 2'd0; din = 8'hEE;
        tick();
        cs = 1'b0; we = 1'b0;
      end
    end
    read_reg(2'd1, rd);
    check("overrun_status1", {24'd0, rd}, 32'h0D);
    read_reg(2'd1, rd);
    check("overrun_status2", {24'd0, rd}, 32'h05);
    wait_idle("overrun_idle");
    check("overrun_drained", exp_q.size(), 32'd0);

    // Pointer wrap-around: 20 bytes in bursts of 4
    for (int burst = 0; burst < 5; burst++) begin
      for (int j = 0; j < 4; j++) write_reg(2'd0, 8'(burst * 4 + j));
      wait_idle("wrap_idle");
    end
    read_reg(2'd1, rd);
    check("wrap_status", {24'd0, rd}, 32'h02);
    check("wrap_drained", exp_q.size(), 32'd0);

    // Interrupt timing
    write_reg(2'd2, 8'h01);
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    write_reg(2'd0, 8'h69);
    check("irq_hold_after_write", {31'd0, irq}, 32'd1);
    tick();
    check("irq_clear", {31'd0, irq}, 32'd0);
    repeat (FRAME) tick();
    check("irq_low_at_stop_end", {31'd0, irq}, 32'd0);
    tick();
    check("irq_return", {31'd0, irq}, 32'd1);
    read_reg(2'd1, rd);
    check("irq_status", {24'd0, rd}, 32'h82);
    write_reg(2'd2, 8'h00);
    tick();

    // Reset in the middle of DATA bit 3
    write_reg(2'd0, 8'h07);
    repeat (70) tick();
    check("pre_reset_bit3", {31'd0, tx_n}, 32'd1);
    reset = 1'b1;
    tick();
    check("midreset_tx_n", {31'd0, tx_n}, 32'd0);
    check("midreset_dout", {24'd0, dout}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    read_reg(2'd1, rd);
    check("midreset_status", {24'd0, rd}, 32'h02);
    begin
      int highs;
      highs = 0;
      repeat (300) begin
        tick();
        if (tx_n) highs++;
      end
      check("midreset_no_frames", highs, 32'd0);
    end

    // Full frame of 0x07 (parity bit is 1 when parity is built in)
    write_reg(2'd0, 8'h07);
    wave_check(8'h07, 8'h00, 1, 1, "frame07_wave");
    wait_idle("final_idle");
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
